// File: rtl/yolov4_layer_seq_if.sv
// Start/done handshake bundle between the layer sequencer and its four engines
// (weight load, ifmap load, conv, ofmap store).
interface yolov4_layer_seq_if;
    logic wgt_start;
    logic ifm_start;
    logic conv_start;
    logic ofm_start;
    logic wgt_done;
    logic ifm_done;
    logic conv_done;
    logic ofm_done;

    modport master (
        output wgt_start, ifm_start, conv_start, ofm_start,
        input  wgt_done,  ifm_done,  conv_done,  ofm_done
    );

    modport slave (
        input  wgt_start, ifm_start, conv_start, ofm_start,
        output wgt_done,  ifm_done,  conv_done,  ofm_done
    );
endinterface

// File: rtl/yolov4_layer_seq.sv
// Layer sequencer for the YOLOv4 accelerator: steps each layer through weight load,
// ifmap load, conv and ofmap store, with per-phase watchdog and abort.
module yolov4_layer_seq #(
    parameter int LAYER_W     = 8,
    parameter int STATE_W     = 4,
    parameter int TIMEOUT_CYC = 65535
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                start,
    input  logic                abort,
    input  logic [LAYER_W-1:0]  num_layers,
    yolov4_layer_seq_if.master  eng,
    output logic [STATE_W-1:0]  state,
    output logic [LAYER_W-1:0]  layer_idx,
    output logic                busy,
    output logic                frame_done,
    output logic                err
);

    localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC + 1) : 1;

    typedef enum logic [3:0] {
        IDLE   = 4'd0,
        LOAD_W = 4'd1,
        LOAD_I = 4'd2,
        CONV   = 4'd3,
        STORE  = 4'd4,
        NEXT   = 4'd5,
        DONE   = 4'd6
    } state_e;

    state_e             state_q, state_d;
    logic [LAYER_W-1:0] nl_q, nl_d;
    logic [LAYER_W-1:0] layer_q, layer_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               first_q, first_d;
    logic               err_q, err_d;
    logic               fdone_q, fdone_d;
    logic [3:0]         pulse_q, pulse_d;   // {ofm, conv, ifm, wgt}

    logic in_phase;
    logic done_ok;
    logic timeout;
    logic entering;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            nl_q    <= '0;
            layer_q <= '0;
            cnt_q   <= '0;
            first_q <= 1'b0;
            err_q   <= 1'b0;
            fdone_q <= 1'b0;
            pulse_q <= '0;
        end else begin
            state_q <= state_d;
            nl_q    <= nl_d;
            layer_q <= layer_d;
            cnt_q   <= cnt_d;
            first_q <= first_d;
            err_q   <= err_d;
            fdone_q <= fdone_d;
            pulse_q <= pulse_d;
        end
    end

    // A done is only honoured from the second cycle of its own phase.
    always_comb begin
        in_phase = state_q inside {LOAD_W, LOAD_I, CONV, STORE};
        done_ok  = 1'b0;
        case (state_q)
            LOAD_W:  done_ok = eng.wgt_done;
            LOAD_I:  done_ok = eng.ifm_done;
            CONV:    done_ok = eng.conv_done;
            STORE:   done_ok = eng.ofm_done;
            default: done_ok = 1'b0;
        endcase
        done_ok = done_ok && !first_q;
        timeout = (TIMEOUT_CYC != 0) && in_phase && !done_ok &&
                  ((32'(cnt_q) + 32'd1) == 32'(TIMEOUT_CYC));
    end

    always_comb begin
        state_d = state_q;
        nl_d    = nl_q;
        layer_d = layer_q;
        err_d   = err_q;

        if (abort) begin
            state_d = IDLE;
            layer_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start && (num_layers != '0)) begin
                        state_d = LOAD_W;
                        nl_d    = num_layers;
                        layer_d = '0;
                        err_d   = 1'b0;
                    end
                end
                // Phase codes are consecutive, so the successor is state+1 (STORE -> NEXT).
                LOAD_W, LOAD_I, CONV, STORE: begin
                    if (done_ok) begin
                        state_d = state_e'(state_q + 4'd1);
                    end else if (timeout) begin
                        state_d = IDLE;
                        err_d   = 1'b1;
                    end
                end
                NEXT: begin
                    if (layer_q == (nl_q - LAYER_W'(1))) begin
                        state_d = DONE;
                    end else begin
                        state_d = LOAD_W;
                        layer_d = layer_q + LAYER_W'(1);
                    end
                end
                DONE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // Registered pulses and watchdog clear are keyed off the transition into a phase.
    always_comb begin
        entering = (state_d != state_q) &&
                   (state_d inside {LOAD_W, LOAD_I, CONV, STORE});
        first_d  = entering;
        pulse_d  = {state_d == STORE, state_d == CONV,
                    state_d == LOAD_I, state_d == LOAD_W} & {4{entering}};
        fdone_d  = (state_d == DONE);
        cnt_d    = cnt_q;
        if (entering) begin
            cnt_d = '0;
        end else if (in_phase && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    assign eng.wgt_start  = pulse_q[0];
    assign eng.ifm_start  = pulse_q[1];
    assign eng.conv_start = pulse_q[2];
    assign eng.ofm_start  = pulse_q[3];
    assign state          = STATE_W'(state_q);
    assign layer_idx      = layer_q;
    assign busy           = (state_q != IDLE);
    assign frame_done     = fdone_q;
    assign err            = err_q;

endmodule

// File: tb/tb_yolov4_layer_seq.sv
// Self-checking bench for yolov4_layer_seq: engine responder, event scoreboard and
// one task per scenario.
module tb_yolov4_layer_seq;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic [7:0] num_layers = 8'd0;
    logic [3:0] state;
    logic [7:0] layer_idx;
    logic       busy, frame_done, err;

    logic [3:0] rdone = 4'd0;
    logic [3:0] mdone = 4'd0;
    logic [3:0] resp_en = 4'hF;
    logic [3:0] starts;
    int         rcnt [4];

    int obs[$];
    int exp_q[$];
    int st_log[$];
    int last_state;
    int n_checks = 0;
    int n_pass = 0;

    yolov4_layer_seq_if eng ();

    assign eng.wgt_done  = rdone[0] | mdone[0];
    assign eng.ifm_done  = rdone[1] | mdone[1];
    assign eng.conv_done = rdone[2] | mdone[2];
    assign eng.ofm_done  = rdone[3] | mdone[3];
    assign starts = {eng.ofm_start, eng.conv_start, eng.ifm_start, eng.wgt_start};

    yolov4_layer_seq #(.LAYER_W(8), .STATE_W(4), .TIMEOUT_CYC(16)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .start      (start),
        .abort      (abort),
        .num_layers (num_layers),
        .eng        (eng),
        .state      (state),
        .layer_idx  (layer_idx),
        .busy       (busy),
        .frame_done (frame_done),
        .err        (err)
    );

    always #5 clk = ~clk;

    // Advance to the next falling edge, log pulses/state, then model the engines:
    // a done follows its start by 3 cycles.
    task automatic step();
        @(negedge clk);
        for (int e = 0; e < 4; e++)
            if (starts[e]) obs.push_back(e * 256 + int'(layer_idx));
        if (frame_done) obs.push_back(4 * 256 + int'(layer_idx));
        if (int'(state) != last_state) begin
            st_log.push_back(int'(state));
            last_state = int'(state);
        end
        for (int e = 0; e < 4; e++) begin
            rdone[e] = 1'b0;
            if (rcnt[e] > 0) begin
                rcnt[e]--;
                if (rcnt[e] == 0) rdone[e] = 1'b1;
            end
            if (starts[e] && resp_en[e]) rcnt[e] = 3;
        end
    endtask

    task automatic clear_logs();
        obs.delete();
        exp_q.delete();
        st_log.delete();
        last_state = int'(state);
    endtask

    task automatic push_layer(input int l, input int nphase);
        for (int p = 0; p < nphase; p++) exp_q.push_back(p * 256 + l);
    endtask

    task automatic kick(input int n);
        num_layers = 8'(n);
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic test_reset_start();
        int req[7] = '{1, 2, 3, 4, 5, 6, 0};
        int e, o;
        rstn = 1'b0;
        repeat (4) step();
        n_checks++;
        if ({state, layer_idx, busy, frame_done, err, starts} !== 20'd0)
            $display("FAIL reset_outputs: got %h required 0",
                     {state, layer_idx, busy, frame_done, err, starts});
        else n_pass++;
        rstn = 1'b1;
        step();
        clear_logs();
        push_layer(0, 4);
        exp_q.push_back(4 * 256 + 0);
        kick(1);
        for (int i = 0; i < 60 && state != 4'd0; i++) step();
        step();
        n_checks++;
        if (state !== 4'd0) $display("FAIL t1_finish: state %0d required 0", state);
        else n_pass++;
        n_checks++;
        if (st_log.size() != 7) $display("FAIL t1_state_count: got %0d required 7", st_log.size());
        else n_pass++;
        for (int i = 0; i < 7 && i < st_log.size(); i++) begin
            n_checks++;
            if (st_log[i] !== req[i]) $display("FAIL t1_state[%0d]: got %0d required %0d", i, st_log[i], req[i]);
            else n_pass++;
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_checks++;
            if (obs.size() == 0) $display("FAIL t1_event: got none required %0h", e);
            else begin
                o = obs.pop_front();
                if (o !== e) $display("FAIL t1_event: got %0h required %0h", o, e);
                else n_pass++;
            end
        end
        n_checks++;
        if (obs.size() != 0) $display("FAIL t1_extra_events: got %0d required 0", obs.size());
        else n_pass++;
        n_checks++;
        if (layer_idx !== 8'd0) $display("FAIL t1_layer_idx: got %0d required 0", layer_idx);
        else n_pass++;
    endtask

    task automatic test_three_layers();
        int e, o;
        clear_logs();
        for (int l = 0; l < 3; l++) push_layer(l, 4);
        exp_q.push_back(4 * 256 + 2);
        kick(3);
        for (int i = 0; i < 200 && state != 4'd0; i++) step();
        step();
        n_checks++;
        if (state !== 4'd0) $display("FAIL t2_finish: state %0d required 0", state);
        else n_pass++;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_checks++;
            if (obs.size() == 0) $display("FAIL t2_event: got none required %0h", e);
            else begin
                o = obs.pop_front();
                if (o !== e) $display("FAIL t2_event: got %0h required %0h", o, e);
                else n_pass++;
            end
        end
        n_checks++;
        if (obs.size() != 0) $display("FAIL t2_extra_events: got %0d required 0", obs.size());
        else n_pass++;
        n_checks++;
        if (layer_idx !== 8'd2) $display("FAIL t2_layer_hold: got %0d required 2", layer_idx);
        else n_pass++;
    endtask

    task automatic test_early_done();
        resp_en[0] = 1'b0;
        clear_logs();
        kick(1);
        mdone[0] = 1'b1;
        step();
        mdone[0] = 1'b0;
        n_checks++;
        if (state !== 4'd1) $display("FAIL t3_early_ignored: state %0d required 1", state);
        else n_pass++;
        step();
        step();
        n_checks++;
        if (state !== 4'd1) $display("FAIL t3_still_loadw: state %0d required 1", state);
        else n_pass++;
        mdone[0] = 1'b1;
        step();
        mdone[0] = 1'b0;
        resp_en[0] = 1'b1;
        n_checks++;
        if (state !== 4'd2) $display("FAIL t3_late_advance: state %0d required 2", state);
        else n_pass++;
        for (int i = 0; i < 60 && state != 4'd0; i++) step();
        n_checks++;
        if (state !== 4'd0 || err !== 1'b0) $display("FAIL t3_finish: state %0d err %0b required 0 0", state, err);
        else n_pass++;
    endtask

    task automatic test_watchdog();
        int e, o;
        int fd;
        resp_en[2] = 1'b0;
        clear_logs();
        push_layer(0, 3);
        kick(1);
        for (int i = 0; i < 100 && state != 4'd0; i++) step();
        repeat (2) step();
        resp_en[2] = 1'b1;
        n_checks++;
        if (state !== 4'd0 || busy !== 1'b0) $display("FAIL t4_idle: state %0d busy %0b required 0 0", state, busy);
        else n_pass++;
        n_checks++;
        if (err !== 1'b1) $display("FAIL t4_err: got %0b required 1", err);
        else n_pass++;
        fd = 0;
        foreach (obs[i]) if (obs[i] / 256 == 4) fd++;
        n_checks++;
        if (fd != 0) $display("FAIL t4_no_frame_done: got %0d required 0", fd);
        else n_pass++;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_checks++;
            if (obs.size() == 0) $display("FAIL t4_event: got none required %0h", e);
            else begin
                o = obs.pop_front();
                if (o !== e) $display("FAIL t4_event: got %0h required %0h", o, e);
                else n_pass++;
            end
        end
        kick(1);
        n_checks++;
        if (err !== 1'b0 || state !== 4'd1) $display("FAIL t4_err_clear: err %0b state %0d required 0 1", err, state);
        else n_pass++;
        for (int i = 0; i < 60 && state != 4'd0; i++) step();
        n_checks++;
        if (state !== 4'd0 || err !== 1'b0) $display("FAIL t4_refinish: state %0d err %0b required 0 0", state, err);
        else n_pass++;
    endtask

    task automatic test_abort();
        int e, o;
        clear_logs();
        push_layer(0, 4);
        push_layer(1, 3);
        kick(3);
        for (int i = 0; i < 60 && state != 4'd5; i++) step();
        resp_en[2] = 1'b0;
        for (int i = 0; i < 60 && state != 4'd3; i++) step();
        step();
        abort = 1'b1;
        mdone[2] = 1'b1;
        step();
        abort = 1'b0;
        mdone[2] = 1'b0;
        resp_en[2] = 1'b1;
        n_checks++;
        if (state !== 4'd0 || busy !== 1'b0) $display("FAIL t5_idle: state %0d busy %0b required 0 0", state, busy);
        else n_pass++;
        n_checks++;
        if (layer_idx !== 8'd0) $display("FAIL t5_layer_idx: got %0d required 0", layer_idx);
        else n_pass++;
        repeat (5) step();
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_checks++;
            if (obs.size() == 0) $display("FAIL t5_event: got none required %0h", e);
            else begin
                o = obs.pop_front();
                if (o !== e) $display("FAIL t5_event: got %0h required %0h", o, e);
                else n_pass++;
            end
        end
        n_checks++;
        if (obs.size() != 0) $display("FAIL t5_extra_events: got %0d required 0", obs.size());
        else n_pass++;
    endtask

    task automatic test_zero_and_reset();
        clear_logs();
        kick(0);
        step();
        n_checks++;
        if (state !== 4'd0 || busy !== 1'b0) $display("FAIL t6_zero_layers: state %0d busy %0b required 0 0", state, busy);
        else n_pass++;
        n_checks++;
        if (obs.size() != 0) $display("FAIL t6_zero_pulses: got %0d required 0", obs.size());
        else n_pass++;
        kick(2);
        for (int i = 0; i < 60 && state != 4'd4; i++) step();
        n_checks++;
        if (state !== 4'd4) $display("FAIL t6_reach_store: state %0d required 4", state);
        else n_pass++;
        #2;
        rstn = 1'b0;
        #1;
        n_checks++;
        if ({state, layer_idx, busy, frame_done, err, starts} !== 20'd0)
            $display("FAIL t6_async_reset: got %h required 0",
                     {state, layer_idx, busy, frame_done, err, starts});
        else n_pass++;
        for (int e = 0; e < 4; e++) rcnt[e] = 0;
        rdone = 4'd0;
        step();
        rstn = 1'b1;
        repeat (2) step();
        n_checks++;
        if (state !== 4'd0 || layer_idx !== 8'd0) $display("FAIL t6_post_reset: state %0d layer %0d required 0 0", state, layer_idx);
        else n_pass++;
    endtask

    initial begin
        for (int e = 0; e < 4; e++) rcnt[e] = 0;
        last_state = 0;
        test_reset_start();
        test_three_layers();
        test_early_done();
        test_watchdog();
        test_abort();
        test_zero_and_reset();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
